phase_err_meter: RTL and testbench

Per-neuron phase-error measurement stage for the ONN neuron control block, wrapped around the first-wave lead/lag detector. It re-arms the detector once per measurement with a one-cycle `re` pulse and times the gap between the rising edges of the reference wave `nin` and the neuron wave `nout`. It then reports a signed phase error in clock cycles and cross-checks its own lead decision against the detector's `flag`. The downstream phase-update logic consumes `err` on `err_valid` to retune the neuron oscillator.

---
 rtl/onn_ctrl_pkg.sv | 16 +
 rtl/phase_err_meter_if.sv | 26 ++
 rtl/phase_err_meter_edge_pulse.sv | 23 ++
 rtl/phase_err_meter.sv | 123 ++++++++++++
 tb/tb_phase_err_meter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/onn_ctrl_pkg.sv
// Shared types and defaults for the ONN neuron control block.
// The CNT_W/TIMEOUT defaults are also used by the phase-update stage.
package onn_ctrl_pkg;

   localparam int unsigned PEM_CNT_W   = 16;
   localparam int unsigned PEM_TIMEOUT = 4095;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT_FIRST,
      S_MEASURE,
      S_REPORT
   } pem_state_t;

endpackage

// File: rtl/phase_err_meter_if.sv
// Detector/report bundle for phase_err_meter.
// master = the meter itself; slave = detector plus downstream consumer.
interface phase_err_meter_if #(
   parameter int unsigned CNT_W = onn_ctrl_pkg::PEM_CNT_W
);
   logic           en;
   logic           nin;
   logic           nout;
   logic           flag;
   logic           re;
   logic [CNT_W:0] err;
   logic           err_valid;
   logic           lead;
   logic           timeout;
   logic           mismatch;

   modport master (
      input  en, nin, nout, flag,
      output re, err, err_valid, lead, timeout, mismatch
   );

   modport slave (
      output en, nin, nout, flag,
      input  re, err, err_valid, lead, timeout, mismatch
   );
endinterface

// File: rtl/phase_err_meter_edge_pulse.sv
// Registered rising-edge detector: a rise sampled at cycle t pulses at t+1,
// matching the alignment of the lead/lag detector's internal pulses.
module edge_pulse (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_pulse
);
   logic r_prev;
   logic r_pulse;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_prev  <= i_d;
         r_pulse <= i_d & ~r_prev;
      end
   end

   assign o_pulse = r_pulse;
endmodule

// File: rtl/phase_err_meter.sv
// Per-neuron phase-error meter: re-arms the lead/lag detector, times the gap
// between nin and nout rising edges and reports a signed error in cycles.
module phase_err_meter
   import onn_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W   = PEM_CNT_W,
   parameter int unsigned TIMEOUT = PEM_TIMEOUT
) (
   input logic               clk,
   input logic               rst_n,
   phase_err_meter_if.master bus
);
   pem_state_t     r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic           r_lead_cur, w_lead_cur_nxt;
   logic [CNT_W:0] r_err, w_err_nxt;
   logic           r_lead, w_lead_nxt;
   logic           r_mismatch, w_mismatch_nxt;
   logic           w_re, w_err_valid, w_timeout;
   logic           w_pin, w_pout;
   logic           w_at_limit;
   logic [CNT_W:0] w_gap_ext;

   edge_pulse u_pin (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_d     (bus.nin),
      .o_pulse (w_pin)
   );

   edge_pulse u_pout (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_d     (bus.nout),
      .o_pulse (w_pout)
   );

   assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT));
   // Widened before the +1 so the gap can reach TIMEOUT+1 without wrapping.
   assign w_gap_ext  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_lead_cur <= 1'b0;
         r_err      <= '0;
         r_lead     <= 1'b0;
         r_mismatch <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_lead_cur <= w_lead_cur_nxt;
         r_err      <= w_err_nxt;
         r_lead     <= w_lead_nxt;
         r_mismatch <= w_mismatch_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_lead_cur_nxt = r_lead_cur;
      w_err_nxt      = r_err;
      w_lead_nxt     = r_lead;
      w_mismatch_nxt = r_mismatch;
      w_re           = 1'b0;
      w_err_valid    = 1'b0;
      w_timeout      = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (bus.en) w_state_nxt = S_ARM;
         end
         S_ARM: begin
            w_re        = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_FIRST;
         end
         S_WAIT_FIRST: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_pin && w_pout) begin
               w_err_nxt   = '0;
               w_lead_nxt  = 1'b1;
               w_state_nxt = S_REPORT;
            end else if (w_pin || w_pout) begin
               w_lead_cur_nxt = w_pin;
               w_cnt_nxt      = '0;
               w_state_nxt    = S_MEASURE;
            end else if (w_at_limit) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_MEASURE: begin
            w_cnt_nxt = r_cnt + 1'b1;
            // Only the trailing wave's edge closes the gap; leader repeats fall through.
            if (r_lead_cur ? w_pout : w_pin) begin
               w_err_nxt   = r_lead_cur ? w_gap_ext : -w_gap_ext;
               w_lead_nxt  = r_lead_cur;
               w_state_nxt = S_REPORT;
            end else if (w_at_limit) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_REPORT: begin
            w_err_valid = 1'b1;
            if (bus.flag != r_lead) w_mismatch_nxt = 1'b1;
            w_state_nxt = bus.en ? S_ARM : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.re        = w_re;
   assign bus.err       = r_err;
   assign bus.err_valid = w_err_valid;
   assign bus.lead      = r_lead;
   assign bus.timeout   = w_timeout;
   assign bus.mismatch  = r_mismatch;
endmodule

// File: tb/tb_phase_err_meter.sv
// Scoreboard bench for phase_err_meter: the driver predicts each measurement
// outcome from edge timings; a negedge monitor checks reports and timeouts.
module tb_phase_err_meter;
   import onn_ctrl_pkg::*;

   localparam int CW = 16;
   localparam int TO = 20;

   typedef struct {
      bit             is_to;
      logic [CW:0]    err;
      bit             lead;
      bit             mis;
      bit             next_re;
      int             cycle;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   model_mis = 1'b0;
   exp_t sbq[$];

   phase_err_meter_if #(.CNT_W(CW)) bus ();

   phase_err_meter #(.CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_re(output int rc, output bit ok);
      ok = 1'b0;
      rc = cyc;
      for (int i = 0; i < 100; i++) begin
         if (bus.re === 1'b1) begin
            ok = 1'b1;
            rc = cyc;
            return;
         end
         tick();
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_re: no re pulse within 100 cycles (cycle %0d)", cyc);
   endtask

   // da/db: cycles after the re cycle at which nin/nout are driven high for one cycle.
   task automatic run_txn(input int da, input int db, input bit wrong, input bit en_drop,
                          output int endc);
      int   r, mn, mx, gap, s, rep_at;
      bit   ok, lead, has_rep;
      exp_t e;
      endc = cyc;
      wait_re(r, ok);
      if (!ok) return;
      lead = (da <= db);
      mn   = lead ? da : db;
      mx   = lead ? db : da;
      gap  = mx - mn;
      if (mn > TO) begin
         e.is_to = 1'b1;
         endc    = r + 1 + TO;
      end else if (gap > TO + 1) begin
         e.is_to = 1'b1;
         endc    = r + 1 + mn + 1 + TO;
      end else begin
         e.is_to = 1'b0;
         endc    = r + 1 + mx + 1;
      end
      s         = lead ? gap : -gap;
      e.err     = s[CW:0];
      e.lead    = lead;
      e.mis     = model_mis;
      e.next_re = e.is_to ? 1'b0 : !en_drop;
      e.cycle   = endc;
      sbq.push_back(e);
      if (!e.is_to && wrong) model_mis = 1'b1;

      has_rep  = (gap >= 3) && ($urandom_range(0, 1) == 1);
      rep_at   = mn + 2;
      bus.flag = lead ^ wrong;
      for (int i = 0; i <= endc - r; i++) begin
         bus.nin  = (i == da) || (lead && has_rep && i == rep_at);
         bus.nout = (i == db) || (!lead && has_rep && i == rep_at);
         if (en_drop && i == 1) bus.en = 1'b0;
         tick();
      end
      bus.nin  = 1'b0;
      bus.nout = 1'b0;
      if (en_drop) begin
         for (int k = 0; k < 4; k++) begin
            check("parked_no_re", 32'(bus.re), 32'd0);
            tick();
         end
         bus.en = 1'b1;
      end
   endtask

   initial begin : monitor
      exp_t e;
      bit   pend_re;
      bit   pend_val;
      pend_re  = 1'b0;
      pend_val = 1'b0;
      forever begin
         @(negedge clk);
         if (pend_re) begin
            check("re_after_event", 32'(bus.re), 32'(pend_val));
            pend_re = 1'b0;
         end
         if (bus.err_valid === 1'b1 || bus.timeout === 1'b1) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_event: err_valid=%0b timeout=%0b, expected none (cycle %0d)",
                        bus.err_valid, bus.timeout, cyc);
            end else begin
               e = sbq.pop_front();
               check("event_kind", 32'({bus.err_valid, bus.timeout}), e.is_to ? 32'd1 : 32'd2);
               check("event_cycle", 32'(cyc), 32'(e.cycle));
               check("re_with_event", 32'(bus.re), 32'd0);
               check("mismatch", 32'(bus.mismatch), 32'(e.mis));
               if (!e.is_to) begin
                  check("err", 32'(bus.err), 32'(e.err));
                  check("lead", 32'(bus.lead), 32'(e.lead));
               end
               pend_re  = 1'b1;
               pend_val = e.next_re;
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : driver
      int endc, r2, x;
      bit ok;
      bus.en   = 1'b0;
      bus.nin  = 1'b0;
      bus.nout = 1'b0;
      bus.flag = 1'b0;
      rst_n    = 1'b0;
      repeat (3) tick();
      check("rst_re", 32'(bus.re), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_err_valid", 32'(bus.err_valid), 32'd0);
      check("rst_lead", 32'(bus.lead), 32'd0);
      check("rst_timeout", 32'(bus.timeout), 32'd0);
      check("rst_mismatch", 32'(bus.mismatch), 32'd0);
      rst_n  = 1'b1;
      bus.en = 1'b1;

      run_txn(0, 5, 1'b0, 1'b0, endc);    // nin leads by 5
      run_txn(12, 0, 1'b0, 1'b0, endc);   // nout leads by 12
      run_txn(4, 4, 1'b0, 1'b0, endc);    // simultaneous
      run_txn(40, 40, 1'b0, 1'b0, endc);  // no edges: wait timeout
      wait_re(r2, ok);
      check("rearm_after_timeout", 32'(r2), 32'(endc + 2));
      run_txn(0, 3, 1'b1, 1'b0, endc);    // flag disagrees
      run_txn(2, 9, 1'b0, 1'b0, endc);    // good report, mismatch held
      run_txn(20, 41, 1'b0, 1'b0, endc);  // largest gap that still reports
      run_txn(0, 22, 1'b0, 1'b0, endc);   // measure timeout
      run_txn(21, 25, 1'b0, 1'b0, endc);  // first edge too late
      run_txn(1, 7, 1'b0, 1'b1, endc);    // en dropped mid-measurement

      for (int n = 0; n < 40; n++) begin
         run_txn(int'($urandom_range(0, 26)), int'($urandom_range(0, 26)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, endc);
      end

      // Reset during MEASURE: no report, all outputs back to reset values.
      wait_re(r2, ok);
      bus.flag = 1'b1;
      bus.nin  = 1'b1;
      tick();
      bus.nin  = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      check("mrst_re", 32'(bus.re), 32'd0);
      check("mrst_err", 32'(bus.err), 32'd0);
      check("mrst_err_valid", 32'(bus.err_valid), 32'd0);
      check("mrst_lead", 32'(bus.lead), 32'd0);
      check("mrst_timeout", 32'(bus.timeout), 32'd0);
      check("mrst_mismatch", 32'(bus.mismatch), 32'd0);
      model_mis = 1'b0;
      tick();
      rst_n = 1'b1;
      x     = cyc;
      wait_re(r2, ok);
      check("rearm_after_reset", 32'(r2), 32'(x + 1));
      run_txn(3, 10, 1'b0, 1'b0, endc);

      repeat (5) tick();
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
